// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared types and encodings for the multi-cycle CPU control FSM.
//   - state_e   : controller state encoding
//   - instr_e   : instruction class decoded from the IR opcode/op fields
//   - nsel / vsel / pc_sel / mem_cmd output encodings
//   - opcode, op and branch-condition constants
//   - decode and branch-condition helper functions
// Optional feature macro: CPU_CTRL_BL_EN (enables BL, BX and BLX decoding).
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET,
    S_IF1,
    S_IF2,
    S_UPDATE_PC,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_EXEC2,
    S_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WRITE_BACK,
    S_BRANCH,
`ifdef CPU_CTRL_BL_EN
    S_LINK,
    S_BRANCH_REG,
`endif
    S_HALT,
    S_FAULT
  } state_e;

  typedef enum logic [3:0] {
    I_MOV_IMM,
    I_MOV_REG,
    I_MVN,
    I_ADD,
    I_AND,
    I_CMP,
    I_LDR,
    I_STR,
    I_B,
    I_BL,
    I_BX,
    I_BLX,
    I_HALT,
    I_ILLEGAL
  } instr_e;

  // One-hot register-file read/write selects
  localparam logic [3:0] NSEL_RN = 4'b0001;
  localparam logic [3:0] NSEL_RD = 4'b0010;
  localparam logic [3:0] NSEL_RM = 4'b0100;

  // Write-back source
  localparam logic [1:0] VSEL_C      = 2'b00;
  localparam logic [1:0] VSEL_SXIMM8 = 2'b10;
  localparam logic [1:0] VSEL_MDATA  = 2'b11;

  // Next-PC source
  localparam logic [1:0] PCSEL_INC = 2'b00;
  localparam logic [1:0] PCSEL_REL = 2'b01;

  // Memory command
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  // Opcodes
  localparam logic [2:0] OPC_B    = 3'b001;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // op sub-codes
  localparam logic [1:0] OP_NONE    = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

`ifdef CPU_CTRL_BL_EN
  localparam logic [1:0] VSEL_PC   = 2'b01;
  localparam logic [1:0] PCSEL_REG = 2'b10;
  localparam logic [2:0] OPC_BL    = 3'b010;
  localparam logic [1:0] OP_BX     = 2'b00;
  localparam logic [1:0] OP_BLX    = 2'b10;
  localparam logic [1:0] OP_BL     = 2'b11;
`endif

  // Branch conditions
  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;

  function automatic instr_e decode_instr(input logic [2:0] opc, input logic [1:0] op);
    instr_e ins;
    ins = I_ILLEGAL;
    case (opc)
      OPC_MOV: begin
        if (op == OP_MOV_IMM)      ins = I_MOV_IMM;
        else if (op == OP_MOV_REG) ins = I_MOV_REG;
      end
      OPC_ALU: begin
        case (op)
          OP_ADD:  ins = I_ADD;
          OP_CMP:  ins = I_CMP;
          OP_AND:  ins = I_AND;
          default: ins = I_MVN;
        endcase
      end
      OPC_LDR: if (op == OP_NONE) ins = I_LDR;
      OPC_STR: if (op == OP_NONE) ins = I_STR;
      OPC_B:   if (op == OP_NONE) ins = I_B;
`ifdef CPU_CTRL_BL_EN
      OPC_BL: begin
        if (op == OP_BL)       ins = I_BL;
        else if (op == OP_BX)  ins = I_BX;
        else if (op == OP_BLX) ins = I_BLX;
      end
`endif
      OPC_HALT: ins = I_HALT;
      default:  ins = I_ILLEGAL;
    endcase
    return ins;
  endfunction

  function automatic logic cond_legal(input logic [2:0] c);
    return (c <= COND_LE);
  endfunction

  function automatic logic cond_taken(input logic [2:0] c, input logic n, input logic v,
                                      input logic z);
    case (c)
      COND_AL: return 1'b1;
      COND_EQ: return z;
      COND_NE: return !z;
      COND_LT: return n ^ v;
      COND_LE: return (n ^ v) | z;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_mem_timer.sv
// cpu_ctrl_mem_timer: wait-state counter with timeout compare for the CPU
// control FSM.
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   wait_i    : controller is in a memory wait state this cycle
//   clr_i     : controller changes state on the next edge (restart count)
//   ready_i   : RAM has completed the access this cycle
//   timeout_o : count has reached MEM_TIMEOUT and the RAM is still not ready
// MEM_TIMEOUT = 0 disables the timeout entirely.
module cpu_ctrl_mem_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wait_i,
  input  logic clr_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The count saturates at CNT_MAX; the FSM leaves the wait state on that
  // cycle either way, so saturation only matters with the timeout disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !wait_i) begin
      cnt_d = '0;
    end else if (!ready_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // ready_i has priority over an expiring count
  assign timeout_o = (MEM_TIMEOUT != 0) && wait_i && !ready_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control FSM for the 16-bit RISC datapath.
// Sequences fetch, decode, ALU, load/store, conditional branch and (optionally)
// branch-and-link, with a mem_ready wait-state handshake and timeout fault.
// Ports:
//   clk, reset_n (async active-low)
//   opcode[2:0], op[1:0], cond[2:0] : IR fields
//   N, V, Z                         : status flags
//   mem_ready                       : RAM access complete
//   nsel[3:0], loada, loadb, loadc, loads, write, asel, bsel, vsel[1:0]
//                                   : datapath controls
//   reset_pc, load_pc, addr_sel, load_ir, load_addr, pc_sel[1:0]
//                                   : PC / IR / address controls
//   mem_cmd[1:0]                    : NONE / READ / WRITE
//   halt, fault                     : sticky status
// Optional feature macro: CPU_CTRL_BL_EN (BL, BX, BLX).
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [3:0]  LINK_SEL    = 4'b1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic       N,
  input  logic       V,
  input  logic       Z,
  input  logic       mem_ready,
  output logic [3:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       reset_pc,
  output logic       load_pc,
  output logic       addr_sel,
  output logic       load_ir,
  output logic       load_addr,
  output logic [1:0] pc_sel,
  output logic [1:0] mem_cmd,
  output logic       halt,
  output logic       fault
);

  // Only the defined register-select lines can ever be driven
  localparam logic [3:0] NSEL_LEGAL = NSEL_RN | NSEL_RD | NSEL_RM | LINK_SEL;

  state_e     state_q, state_d;
  instr_e     ins;
  logic       in_wait;
  logic       wait_clr;
  logic       timeout;
  logic [3:0] nsel_sel;

  assign ins      = decode_instr(opcode, op);
  assign in_wait  = (state_q == S_IF1) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign wait_clr = (state_d != state_q);

  cpu_ctrl_mem_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_timer (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .wait_i   (in_wait),
    .clr_i    (wait_clr),
    .ready_i  (mem_ready),
    .timeout_o(timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_RESET;
    else          state_q <= state_d;
  end

  // Next-state logic. Mid-sequence states branch on the decoded instruction;
  // the IR is stable from IF2 to the next IF2 so this is safe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:     state_d = S_IF1;
      S_IF1: begin
        if (mem_ready)    state_d = S_IF2;
        else if (timeout) state_d = S_FAULT;
      end
      S_IF2:       state_d = S_UPDATE_PC;
      S_UPDATE_PC: state_d = S_DECODE;
      S_DECODE: begin
        case (ins)
          I_MOV_IMM:                       state_d = S_WRITE_BACK;
          I_MOV_REG, I_MVN:                state_d = S_GET_B;
          I_ADD, I_AND, I_CMP:             state_d = S_GET_A;
          I_LDR, I_STR:                    state_d = S_GET_A;
          I_B: begin
            if (!cond_legal(cond))                state_d = S_FAULT;
            else if (cond_taken(cond, N, V, Z))   state_d = S_BRANCH;
            else                                  state_d = S_IF1;
          end
`ifdef CPU_CTRL_BL_EN
          I_BL:                            state_d = S_LINK;
          I_BX, I_BLX:                     state_d = S_GET_B;
`endif
          I_HALT:                          state_d = S_HALT;
          default:                         state_d = S_FAULT;
        endcase
      end
      S_GET_A: begin
        case (ins)
          I_ADD, I_AND, I_CMP: state_d = S_GET_B;
          I_LDR, I_STR:        state_d = S_EXEC;
          default:             state_d = S_FAULT;
        endcase
      end
      S_GET_B: begin
        case (ins)
          I_STR:   state_d = S_EXEC2;
`ifdef CPU_CTRL_BL_EN
          I_BLX:   state_d = S_LINK;
`endif
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (ins)
          I_CMP:                              state_d = S_IF1;
          I_MOV_REG, I_MVN, I_ADD, I_AND:     state_d = S_WRITE_BACK;
          I_LDR, I_STR:                       state_d = S_ADDR;
`ifdef CPU_CTRL_BL_EN
          I_BX, I_BLX:                        state_d = S_BRANCH_REG;
`endif
          default:                            state_d = S_FAULT;
        endcase
      end
      // STR reuses ADDR before fetching the store data from Rd
      S_ADDR:      state_d = (ins == I_LDR) ? S_MEM_RD : S_GET_B;
      S_EXEC2:     state_d = S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)    state_d = S_WRITE_BACK;
        else if (timeout) state_d = S_FAULT;
      end
      S_MEM_WR: begin
        if (mem_ready)    state_d = S_IF1;
        else if (timeout) state_d = S_FAULT;
      end
      S_WRITE_BACK: state_d = S_IF1;
      S_BRANCH:     state_d = S_IF1;
`ifdef CPU_CTRL_BL_EN
      // BLX has already read Rd, so the link write cannot disturb the target
      S_LINK:       state_d = (ins == I_BLX) ? S_EXEC : S_BRANCH;
      S_BRANCH_REG: state_d = S_IF1;
`endif
      S_HALT:       state_d = S_HALT;
      S_FAULT:      state_d = S_FAULT;
      default:      state_d = S_FAULT;
    endcase
  end

  // Output decode from state and instruction class
  always_comb begin
    nsel_sel  = '0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    write     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    vsel      = VSEL_C;
    reset_pc  = 1'b0;
    load_pc   = 1'b0;
    addr_sel  = 1'b0;
    load_ir   = 1'b0;
    load_addr = 1'b0;
    pc_sel    = PCSEL_INC;
    mem_cmd   = MEM_NONE;
    halt      = 1'b0;
    fault     = 1'b0;
    case (state_q)
      S_RESET: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
      end
      S_IF1: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
      end
      S_IF2: begin
        addr_sel = 1'b1;
        mem_cmd  = MEM_READ;
        load_ir  = 1'b1;
      end
      S_UPDATE_PC: begin
        load_pc = 1'b1;
        pc_sel  = PCSEL_INC;
      end
      S_GET_A: begin
        loada    = 1'b1;
        nsel_sel = NSEL_RN;
      end
      S_GET_B: begin
        loadb    = 1'b1;
        nsel_sel = (ins == I_STR || ins == I_BX || ins == I_BLX) ? NSEL_RD : NSEL_RM;
      end
      S_EXEC: begin
        if (ins == I_CMP) loads = 1'b1;
        else              loadc = 1'b1;
        asel = (ins == I_MOV_REG) || (ins == I_MVN) || (ins == I_BX) || (ins == I_BLX);
        bsel = (ins == I_LDR) || (ins == I_STR);
      end
      S_EXEC2: begin
        loadc = 1'b1;
        asel  = 1'b1;
      end
      S_ADDR:   load_addr = 1'b1;
      S_MEM_RD: mem_cmd   = MEM_READ;
      S_MEM_WR: mem_cmd   = MEM_WRITE;
      S_WRITE_BACK: begin
        write = 1'b1;
        case (ins)
          I_MOV_IMM: begin
            nsel_sel = NSEL_RN;
            vsel     = VSEL_SXIMM8;
          end
          I_LDR: begin
            nsel_sel = NSEL_RD;
            vsel     = VSEL_MDATA;
          end
          default: begin
            nsel_sel = NSEL_RD;
            vsel     = VSEL_C;
          end
        endcase
      end
      S_BRANCH: begin
        load_pc = 1'b1;
        pc_sel  = PCSEL_REL;
      end
`ifdef CPU_CTRL_BL_EN
      S_LINK: begin
        nsel_sel = LINK_SEL;
        vsel     = VSEL_PC;
        write    = 1'b1;
      end
      S_BRANCH_REG: begin
        load_pc = 1'b1;
        pc_sel  = PCSEL_REG;
      end
`endif
      S_HALT:  halt  = 1'b1;
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign nsel = nsel_sel & NSEL_LEGAL;

endmodule
